// File: rtl/wb_write_buffer.sv
// wb_write_buffer: in-order write-back queue in front of the register file
// write port, with youngest-match forwarding for both read ports.
// Optional build macro WB_ZERO_REG_EN: writes to register 0 are accepted but
// dropped, and register 0 never produces a forwarding hit.
module wb_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [DW-1:0]              in_data,
  input  logic                       drain_en,
  output logic                       rf_we,
  output logic [AW-1:0]              rf_addr3,
  output logic [DW-1:0]              rf_wd,
  input  logic [AW-1:0]              fwd_addr1,
  input  logic [AW-1:0]              fwd_addr2,
  output logic                       fwd_hit1,
  output logic                       fwd_hit2,
  output logic [DW-1:0]              fwd_data1,
  output logic [DW-1:0]              fwd_data2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [AW-1:0] entry_addr_q [DEPTH];
  logic [DW-1:0] entry_data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic empty, full, push, pop;
  logic [IW-1:0] head_idx;

  assign head_idx = rd_ptr_q[IW-1:0];

  // Occupancy flags, handshake, drain port and pointer advance.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) &&
               (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
    in_ready = !full;
`ifdef WB_ZERO_REG_EN
    // Register 0 is hardwired; the request is consumed but never stored.
    push     = in_valid && !full && (in_addr != '0);
`else
    push     = in_valid && !full;
`endif
    pop      = !empty && drain_en;
    rf_we    = pop;
    rf_addr3 = empty ? '0 : entry_addr_q[head_idx];
    rf_wd    = empty ? '0 : entry_data_q[head_idx];
    count    = wr_ptr_q - rd_ptr_q;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  // Pointer registers; reset discards every pending write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr_q[wr_ptr_q[IW-1:0]] <= in_addr;
      entry_data_q[wr_ptr_q[IW-1:0]] <= in_data;
    end
  end

  // Forwarding: walk oldest to youngest so the youngest match overrides.
  always_comb begin
    logic [IW-1:0] idx;
    logic          occ;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    idx       = '0;
    occ       = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_idx + IW'(i);
      occ = (PW'(i) < count);
`ifdef WB_ZERO_REG_EN
      if (occ && (fwd_addr1 != '0) && (entry_addr_q[idx] == fwd_addr1)) begin
`else
      if (occ && (entry_addr_q[idx] == fwd_addr1)) begin
`endif
        fwd_hit1  = 1'b1;
        fwd_data1 = entry_data_q[idx];
      end
`ifdef WB_ZERO_REG_EN
      if (occ && (fwd_addr2 != '0) && (entry_addr_q[idx] == fwd_addr2)) begin
`else
      if (occ && (entry_addr_q[idx] == fwd_addr2)) begin
`endif
        fwd_hit2  = 1'b1;
        fwd_data2 = entry_data_q[idx];
      end
    end
  end

endmodule
